z16_mem_arbiter: RTL and testbench
==================================

Name: z16_mem_arbiter

Overview:
Shares the single-port Z16 memory between the instruction-fetch requester (IF) and the load/store requester (LS). Grants one access per cycle, drives the memory port, and routes the 1-cycle-latency read data back to the correct requester. Sits between the fetch/execute stages and the memory, in front of the instruction/data memory array.

Parameters:
ADDR_W, 16, address width (Z16 byte address)
DATA_W, 16, data / instruction width
MAX_WAIT, 4, IF starvation threshold in cycles (used only with Z16_ARB_STARVE_EN)
WAIT_W, 3, width of the starvation counter; must hold MAX_WAIT

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_flush  in  1  pipeline flush: drop the pending fetch response, block IF grant this cycle
i_if_req  in  1  fetch request
i_if_addr  in  ADDR_W  fetch address
o_if_gnt  out  1  fetch accepted this cycle
o_if_rvalid  out  1  fetch data valid
o_if_rdata  out  DATA_W  fetched instruction
i_ls_req  in  1  load/store request
i_ls_we  in  1  1 = store, 0 = load
i_ls_addr  in  ADDR_W  load/store address
i_ls_wdata  in  DATA_W  store data
o_ls_gnt  out  1  load/store accepted this cycle
o_ls_rvalid  out  1  load data valid
o_ls_rdata  out  DATA_W  load data
o_mem_en  out  1  memory access strobe
o_mem_we  out  1  memory write enable
o_mem_addr  out  ADDR_W  memory address
o_mem_wdata  out  DATA_W  memory write data
i_mem_rdata  in  DATA_W  memory read data, valid the cycle after o_mem_en with o_mem_we=0

Behaviour:
- Reset (i_rst_n=0, asynchronous): o_if_rvalid=0, o_ls_rvalid=0, internal owner/pending registers 0, starvation counter 0. While reset is asserted, o_if_gnt, o_ls_gnt, o_mem_en and o_mem_we are forced to 0.
- Grant is combinational in cycle N. Requesters hold req/addr/data stable until they see gnt.
- Arbitration in cycle N: LS wins over IF when both request (base fixed priority). IF is eligible only when i_flush=0. At most one grant per cycle, and o_mem_en = o_if_gnt | o_ls_gnt.
- Memory port muxed from the winner. For IF: o_mem_we=0. For LS: o_mem_we=i_ls_we and o_mem_wdata=i_ls_wdata. With no grant: o_mem_en=0, o_mem_we=0, and addr/wdata hold the last values (don't-care).
- Response registers capture at the clock edge ending cycle N:
  - if_pend = o_if_gnt
  - ls_pend = o_ls_gnt & ~i_ls_we
- Response in cycle N+1:
  - o_if_rvalid = if_pend & ~i_flush
  - o_ls_rvalid = ls_pend
  - o_if_rdata = o_ls_rdata = i_mem_rdata (passthrough). Consumers qualify with rvalid.
- Stores produce no rvalid. A store is complete on grant.
- Fully pipelined: a new grant may be issued in the same cycle a previous response is returned. Sustained throughput is 1 access/cycle.
- Flush in cycle N: suppresses o_if_rvalid for the fetch granted in N-1 and blocks the IF grant in N. LS traffic is unaffected. if_pend still clears normally.
- Reset mid-operation: a pending response is discarded, and no rvalid appears after reset is released.
- Misaligned addresses are passed through unchanged. Alignment checking belongs to the requesters.

Optional Feature:
Z16_ARB_STARVE_EN
- Defined:
  - A WAIT_W-bit counter increments (saturating) each cycle with i_if_req=1, o_if_gnt=0 and i_flush=0.
  - The counter clears on an IF grant, or when i_if_req=0 or i_flush=1.
  - When counter >= MAX_WAIT, IF wins a simultaneous conflict with LS. After that grant, the counter clears and LS priority resumes.
- Undefined: the counter logic is absent and arbitration is strictly LS > IF.

Test Plan:
1. IF only, memory preloaded: i_if_addr 0x0000, 0x0002, 0x0004, 0x0006, 0x0008 on consecutive cycles -> o_if_gnt=1 in each cycle; o_if_rvalid=1 one cycle later with o_if_rdata = mem[addr]; o_ls_rvalid stays 0.
2. IF read 0x0004 and LS load 0x0020 together -> cycle N: o_ls_gnt=1, o_if_gnt=0, o_mem_addr=0x0020. Cycle N+1: o_ls_rvalid=1 with mem[0x0020], o_if_gnt=1, o_mem_addr=0x0004. Cycle N+2: o_if_rvalid=1.
3. LS store i_ls_addr=0x0010, i_ls_wdata=0xBEEF -> o_mem_en=1, o_mem_we=1, o_mem_wdata=0xBEEF, no o_ls_rvalid. A following load of 0x0010 returns 0xBEEF.
4. With Z16_ARB_STARVE_EN and MAX_WAIT=4, LS and IF requesting continuously -> LS granted 4 cycles, IF granted in cycle 5, then LS again. Without the macro, IF is never granted.
5. Fetch granted in cycle N, i_flush=1 in cycle N+1 -> o_if_rvalid=0 in N+1 and o_if_gnt=0 in N+1. A fetch requested in N+2 is granted normally.
6. LS load granted in cycle N, i_rst_n driven low mid-cycle N -> o_ls_rvalid=0 immediately and throughout reset. No rvalid after release. With the macro, the counter reads 0.

Source files
------------

// File: rtl/z16_mem_arbiter_if.sv
// z16_mem_arbiter_if: bus bundle between the fetch/load-store requesters,
// the arbiter and the single-port Z16 memory.
//
// Handshake: a requester raises *_req with address/data and holds them
// stable until it sees *_gnt; a transfer occurs in every cycle where
// req & gnt. Read data returns one cycle later, qualified by *_rvalid
// (there is no back-pressure on responses).
interface z16_mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              i_flush;
   logic              i_if_req;
   logic [ADDR_W-1:0] i_if_addr;
   logic              o_if_gnt;
   logic              o_if_rvalid;
   logic [DATA_W-1:0] o_if_rdata;
   logic              i_ls_req;
   logic              i_ls_we;
   logic [ADDR_W-1:0] i_ls_addr;
   logic [DATA_W-1:0] i_ls_wdata;
   logic              o_ls_gnt;
   logic              o_ls_rvalid;
   logic [DATA_W-1:0] o_ls_rdata;
   logic              o_mem_en;
   logic              o_mem_we;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [DATA_W-1:0] o_mem_wdata;
   logic [DATA_W-1:0] i_mem_rdata;

   // Arbiter side.
   modport slave (
      input  i_flush, i_if_req, i_if_addr, i_ls_req, i_ls_we, i_ls_addr,
             i_ls_wdata, i_mem_rdata,
      output o_if_gnt, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_rvalid,
             o_ls_rdata, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
   );

   // Requester / memory side.
   modport master (
      output i_flush, i_if_req, i_if_addr, i_ls_req, i_ls_we, i_ls_addr,
             i_ls_wdata, i_mem_rdata,
      input  o_if_gnt, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_rvalid,
             o_ls_rdata, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
   );
endinterface

// File: rtl/z16_mem_arbiter.sv
// z16_mem_arbiter: shares the single-port Z16 memory between instruction
// fetch (IF) and load/store (LS). One grant per cycle, LS has priority,
// read data (1-cycle latency) is routed back to whoever issued the read.
// Optional macro Z16_ARB_STARVE_EN: an IF wait counter lets IF win a
// conflict after MAX_WAIT lost cycles. The counter is visible on
// o_dbg_wait_cnt (always 0 when the macro is undefined).
module z16_mem_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 4,
   parameter int WAIT_W   = 3
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   z16_mem_arbiter_if.slave  bus,
   output logic [WAIT_W-1:0] o_dbg_wait_cnt
);
   logic              if_ok;
   logic              if_first;
   logic              if_gnt;
   logic              ls_gnt;
   logic              if_pend_q;
   logic              ls_pend_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

`ifdef Z16_ARB_STARVE_EN
   logic [WAIT_W-1:0] wait_q;

   // Count cycles IF waits without a flush; clear on grant, drop or flush.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wait_q <= '0;
      end else if (if_gnt || !bus.i_if_req || bus.i_flush) begin
         wait_q <= '0;
      end else if (wait_q != '1) begin
         wait_q <= wait_q + WAIT_W'(1);
      end
   end

   assign if_first       = (wait_q >= WAIT_W'(MAX_WAIT));
   assign o_dbg_wait_cnt = wait_q;
`else
   assign if_first       = 1'b0;
   assign o_dbg_wait_cnt = '0;
`endif

   // Grant decision: LS first unless a starved IF is promoted; reset blocks all.
   always_comb begin
      if_ok  = bus.i_if_req & ~bus.i_flush;
      ls_gnt = i_rst_n & bus.i_ls_req & ~(if_ok & if_first);
      if_gnt = i_rst_n & if_ok & ~(bus.i_ls_req & ~if_first);
   end

   // Memory port mux; address/data hold their last value when idle.
   always_comb begin
      bus.o_if_gnt    = if_gnt;
      bus.o_ls_gnt    = ls_gnt;
      bus.o_mem_en    = if_gnt | ls_gnt;
      bus.o_mem_we    = ls_gnt & bus.i_ls_we;
      bus.o_mem_addr  = addr_q;
      bus.o_mem_wdata = wdata_q;
      if (ls_gnt) begin
         bus.o_mem_addr  = bus.i_ls_addr;
         bus.o_mem_wdata = bus.i_ls_wdata;
      end else if (if_gnt) begin
         bus.o_mem_addr  = bus.i_if_addr;
      end
   end

   // Remember who owns next cycle's read data, and the last port values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         if_pend_q <= 1'b0;
         ls_pend_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         if_pend_q <= if_gnt;
         ls_pend_q <= ls_gnt & ~bus.i_ls_we;
         if (bus.o_mem_en) begin
            addr_q  <= bus.o_mem_addr;
            wdata_q <= bus.o_mem_wdata;
         end
      end
   end

   // Response routing; a flush kills the fetch returning this cycle.
   always_comb begin
      bus.o_if_rvalid = if_pend_q & ~bus.i_flush;
      bus.o_ls_rvalid = ls_pend_q;
      bus.o_if_rdata  = bus.i_mem_rdata;
      bus.o_ls_rdata  = bus.i_mem_rdata;
   end
endmodule

// File: tb/tb_z16_mem_arbiter.sv
// tb_z16_mem_arbiter: table vectors, directed multi-cycle sequences and a
// randomized run against a behavioural model of the arbitration rules.
module tb_z16_mem_arbiter;
   localparam int MAX_WAIT = 4;
   localparam int WAIT_W   = 3;
`ifdef Z16_ARB_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif

   typedef struct {
      logic        fl;
      logic        ir;
      logic [15:0] ia;
      logic        lr;
      logic        lw;
      logic [15:0] la;
      logic [15:0] lwd;
      logic        e_if;
      logic        e_ls;
      logic        e_we;
      logic [15:0] e_addr;
      logic [15:0] e_wdata;
   } vec_t;

   logic              clk;
   logic              rst_n;
   logic [WAIT_W-1:0] dbg_wait;
   logic [15:0]       mem     [0:255];
   logic [15:0]       ref_mem [0:255];
   logic [15:0]       mem_rdata_q;
   logic [16:0]       exp_q[$];
   vec_t              tbl [9];
   int                errors;
   int                checks;

   z16_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   z16_mem_arbiter #(
      .ADDR_W(16), .DATA_W(16), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .bus(bus),
      .o_dbg_wait_cnt(dbg_wait)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- memory model (word-indexed, 1-cycle read) ----------------
   always @(posedge clk) begin
      if (bus.o_mem_en) begin
         if (bus.o_mem_we) mem[bus.o_mem_addr[8:1]] <= bus.o_mem_wdata;
         else              mem_rdata_q <= mem[bus.o_mem_addr[8:1]];
      end
   end
   assign bus.i_mem_rdata = mem_rdata_q;

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic fl, input logic ir, input logic [15:0] ia,
                        input logic lr, input logic lw, input logic [15:0] la,
                        input logic [15:0] lwd);
      bus.i_flush    = fl;
      bus.i_if_req   = ir;
      bus.i_if_addr  = ia;
      bus.i_ls_req   = lr;
      bus.i_ls_we    = lw;
      bus.i_ls_addr  = la;
      bus.i_ls_wdata = lwd;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rd(input logic [15:0] a);
      return ref_mem[a[8:1]];
   endfunction

   // ---------------- randomized-run variables ----------------
   logic        r_ir, r_lr, r_lw, r_fl;
   logic [15:0] r_ia, r_la, r_lwd;
   logic        e_if, e_ls, last_if, last_ls;
   logic [16:0] ent;
   int          cnt;

   initial begin
      errors = 0;
      checks = 0;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 16'(i * 16'h0123) ^ 16'h5A00;
         ref_mem[i] = 16'(i * 16'h0123) ^ 16'h5A00;
      end

      tbl[0] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
      tbl[1] = '{1'b0, 1'b1, 16'h0012, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0012, 16'h0000};
      tbl[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000};
      tbl[3] = '{1'b0, 1'b1, 16'h0014, 1'b1, 1'b0, 16'h0032, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0032, 16'h0000};
      tbl[4] = '{1'b0, 1'b1, 16'h0016, 1'b1, 1'b1, 16'h0140, 16'h1234, 1'b0, 1'b1, 1'b1, 16'h0140, 16'h1234};
      tbl[5] = '{1'b1, 1'b1, 16'h0018, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
      tbl[6] = '{1'b1, 1'b1, 16'h001A, 1'b1, 1'b0, 16'h0034, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0034, 16'h0000};
      tbl[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0151, 16'hCAFE, 1'b0, 1'b1, 1'b1, 16'h0151, 16'hCAFE};
      tbl[8] = '{1'b0, 1'b1, 16'h0007, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0007, 16'h0000};

      // ---- reset: grants forced low even with requests pending ----
      rst_n = 1'b0;
      drive(1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 16'h0004, 16'h0000);
      #2;
      chk("rst_if_gnt", 32'(bus.o_if_gnt), 32'd0);
      chk("rst_ls_gnt", 32'(bus.o_ls_gnt), 32'd0);
      chk("rst_mem_en", 32'(bus.o_mem_en), 32'd0);
      chk("rst_mem_we", 32'(bus.o_mem_we), 32'd0);
      next_cycle();
      chk("rst_if_rvalid", 32'(bus.o_if_rvalid), 32'd0);
      chk("rst_ls_rvalid", 32'(bus.o_ls_rvalid), 32'd0);
      chk("rst_wait_cnt", 32'(dbg_wait), 32'd0);
      idle();
      rst_n = 1'b1;
      next_cycle();

      // ---- 1: IF-only streaming ----
      for (int k = 0; k < 6; k++) begin
         if (k < 5) drive(1'b0, 1'b1, 16'(2 * k), 1'b0, 1'b0, 16'h0, 16'h0);
         else       idle();
         @(negedge clk);
         if (k < 5) begin
            chk("t1_if_gnt", 32'(bus.o_if_gnt), 32'd1);
            chk("t1_mem_addr", 32'(bus.o_mem_addr), 32'(2 * k));
            chk("t1_mem_we", 32'(bus.o_mem_we), 32'd0);
         end
         if (k > 0) begin
            chk("t1_if_rvalid", 32'(bus.o_if_rvalid), 32'd1);
            chk("t1_if_rdata", 32'(bus.o_if_rdata), 32'(rd(16'(2 * (k - 1)))));
         end
         chk("t1_ls_rvalid", 32'(bus.o_ls_rvalid), 32'd0);
         next_cycle();
      end

      // ---- 2: conflict, LS first then IF ----
      drive(1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 16'h0020, 16'h0);
      @(negedge clk);
      chk("t2_ls_gnt", 32'(bus.o_ls_gnt), 32'd1);
      chk("t2_if_gnt0", 32'(bus.o_if_gnt), 32'd0);
      chk("t2_addr0", 32'(bus.o_mem_addr), 32'h0020);
      next_cycle();
      drive(1'b0, 1'b1, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      chk("t2_ls_rvalid", 32'(bus.o_ls_rvalid), 32'd1);
      chk("t2_ls_rdata", 32'(bus.o_ls_rdata), 32'(rd(16'h0020)));
      chk("t2_if_gnt1", 32'(bus.o_if_gnt), 32'd1);
      chk("t2_addr1", 32'(bus.o_mem_addr), 32'h0004);
      next_cycle();
      idle();
      @(negedge clk);
      chk("t2_if_rvalid", 32'(bus.o_if_rvalid), 32'd1);
      chk("t2_if_rdata", 32'(bus.o_if_rdata), 32'(rd(16'h0004)));
      chk("t2_ls_rvalid_end", 32'(bus.o_ls_rvalid), 32'd0);
      next_cycle();

      // ---- 3: store then load-back ----
      drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
      @(negedge clk);
      chk("t3_mem_en", 32'(bus.o_mem_en), 32'd1);
      chk("t3_mem_we", 32'(bus.o_mem_we), 32'd1);
      chk("t3_wdata", 32'(bus.o_mem_wdata), 32'hBEEF);
      ref_mem[8] = 16'hBEEF;
      next_cycle();
      drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0);
      @(negedge clk);
      chk("t3_store_no_rvalid", 32'(bus.o_ls_rvalid), 32'd0);
      chk("t3_load_we", 32'(bus.o_mem_we), 32'd0);
      next_cycle();
      idle();
      @(negedge clk);
      chk("t3_load_rvalid", 32'(bus.o_ls_rvalid), 32'd1);
      chk("t3_load_rdata", 32'(bus.o_ls_rdata), 32'hBEEF);
      next_cycle();

      // ---- 4: continuous conflict (starvation promotion when enabled) ----
      for (int c = 0; c < 6; c++) begin
         drive(1'b0, 1'b1, 16'h0008, 1'b1, 1'b0, 16'h0030, 16'h0);
         @(negedge clk);
         chk("t4_if_gnt", 32'(bus.o_if_gnt), 32'(STARVE && c == MAX_WAIT));
         chk("t4_ls_gnt", 32'(bus.o_ls_gnt), 32'(!(STARVE && c == MAX_WAIT)));
         next_cycle();
      end
      idle();
      next_cycle();

      // ---- 5: flush kills returning fetch and blocks IF grant ----
      drive(1'b0, 1'b1, 16'h0006, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      chk("t5_if_gnt0", 32'(bus.o_if_gnt), 32'd1);
      next_cycle();
      drive(1'b1, 1'b1, 16'h000A, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      chk("t5_flush_rvalid", 32'(bus.o_if_rvalid), 32'd0);
      chk("t5_flush_gnt", 32'(bus.o_if_gnt), 32'd0);
      chk("t5_flush_en", 32'(bus.o_mem_en), 32'd0);
      next_cycle();
      drive(1'b0, 1'b1, 16'h000A, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      chk("t5_if_gnt2", 32'(bus.o_if_gnt), 32'd1);
      chk("t5_no_stale_rvalid", 32'(bus.o_if_rvalid), 32'd0);
      next_cycle();
      idle();
      @(negedge clk);
      chk("t5_if_rvalid", 32'(bus.o_if_rvalid), 32'd1);
      chk("t5_if_rdata", 32'(bus.o_if_rdata), 32'(rd(16'h000A)));
      next_cycle();

      // ---- 6: reset in the middle of a load ----
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 1'b1, 16'h0008, 1'b1, 1'b0, 16'h0020, 16'h0);
         @(negedge clk);
         chk("t6_ls_gnt", 32'(bus.o_ls_gnt), 32'd1);
         if (c < 2) next_cycle();
      end
      chk("t6_ls_rvalid_pre", 32'(bus.o_ls_rvalid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rvalid_now", 32'(bus.o_ls_rvalid), 32'd0);
      chk("t6_gnt_now", 32'(bus.o_ls_gnt), 32'd0);
      chk("t6_en_now", 32'(bus.o_mem_en), 32'd0);
      chk("t6_wait_cnt", 32'(dbg_wait), 32'd0);
      next_cycle();
      chk("t6_rvalid_rst", 32'(bus.o_ls_rvalid), 32'd0);
      idle();
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("t6_ls_rvalid_post", 32'(bus.o_ls_rvalid), 32'd0);
         chk("t6_if_rvalid_post", 32'(bus.o_if_rvalid), 32'd0);
         next_cycle();
      end

      // ---- table vectors (each followed by an idle cycle) ----
      for (int v = 0; v < 9; v++) begin
         drive(tbl[v].fl, tbl[v].ir, tbl[v].ia, tbl[v].lr, tbl[v].lw, tbl[v].la, tbl[v].lwd);
         @(negedge clk);
         chk($sformatf("tbl%0d_if_gnt", v), 32'(bus.o_if_gnt), 32'(tbl[v].e_if));
         chk($sformatf("tbl%0d_ls_gnt", v), 32'(bus.o_ls_gnt), 32'(tbl[v].e_ls));
         chk($sformatf("tbl%0d_mem_en", v), 32'(bus.o_mem_en), 32'(tbl[v].e_if | tbl[v].e_ls));
         chk($sformatf("tbl%0d_mem_we", v), 32'(bus.o_mem_we), 32'(tbl[v].e_we));
         if (tbl[v].e_if || tbl[v].e_ls)
            chk($sformatf("tbl%0d_mem_addr", v), 32'(bus.o_mem_addr), 32'(tbl[v].e_addr));
         if (tbl[v].e_we) begin
            chk($sformatf("tbl%0d_wdata", v), 32'(bus.o_mem_wdata), 32'(tbl[v].e_wdata));
            ref_mem[tbl[v].e_addr[8:1]] = tbl[v].e_wdata;
         end
         next_cycle();
         idle();
         next_cycle();
      end

      // ---- randomized run against the reference model ----
      cnt     = 0;
      exp_q   = {};
      r_ir    = 1'b0;
      r_lr    = 1'b0;
      last_if = 1'b1;
      last_ls = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if (!r_ir || last_if) begin
            r_ir = ($urandom_range(0, 3) != 0);
            r_ia = {7'b0, 8'($urandom_range(0, 31)), 1'b0};
         end
         if (!r_lr || last_ls) begin
            r_lr  = ($urandom_range(0, 2) != 0);
            r_lw  = ($urandom_range(0, 2) == 0);
            r_la  = {7'b0, 8'($urandom_range(0, 31)), 1'b0};
            r_lwd = 16'($urandom_range(0, 65535));
         end
         r_fl = ($urandom_range(0, 9) == 0);
         drive(r_fl, r_ir, r_ia, r_lr, r_lw, r_la, r_lwd);
         @(negedge clk);
         e_ls = r_lr && !(r_ir && !r_fl && STARVE && cnt >= MAX_WAIT);
         e_if = r_ir && !r_fl && !e_ls;
         chk("rnd_if_gnt", 32'(bus.o_if_gnt), 32'(e_if));
         chk("rnd_ls_gnt", 32'(bus.o_ls_gnt), 32'(e_ls));
         chk("rnd_mem_en", 32'(bus.o_mem_en), 32'(e_if || e_ls));
         chk("rnd_mem_we", 32'(bus.o_mem_we), 32'(e_ls && r_lw));
         if (e_ls) chk("rnd_mem_addr", 32'(bus.o_mem_addr), 32'(r_la));
         if (e_if) chk("rnd_mem_addr", 32'(bus.o_mem_addr), 32'(r_ia));
         if (e_ls && r_lw) chk("rnd_wdata", 32'(bus.o_mem_wdata), 32'(r_lwd));
         // response owed from last cycle
         if (exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            if (ent[16]) begin
               chk("rnd_ls_rvalid", 32'(bus.o_ls_rvalid), 32'd1);
               chk("rnd_ls_rdata", 32'(bus.o_ls_rdata), 32'(ent[15:0]));
               chk("rnd_if_rvalid", 32'(bus.o_if_rvalid), 32'd0);
            end else begin
               chk("rnd_if_rvalid", 32'(bus.o_if_rvalid), 32'(!r_fl));
               if (!r_fl) chk("rnd_if_rdata", 32'(bus.o_if_rdata), 32'(ent[15:0]));
               chk("rnd_ls_rvalid", 32'(bus.o_ls_rvalid), 32'd0);
            end
         end else begin
            chk("rnd_if_rvalid", 32'(bus.o_if_rvalid), 32'd0);
            chk("rnd_ls_rvalid", 32'(bus.o_ls_rvalid), 32'd0);
         end
         if (e_if) exp_q.push_back({1'b0, rd(r_ia)});
         if (e_ls && !r_lw) exp_q.push_back({1'b1, rd(r_la)});
         if (e_ls && r_lw) ref_mem[r_la[8:1]] = r_lwd;
         if (e_if || !r_ir || r_fl) cnt = 0;
         else if (cnt < (1 << WAIT_W) - 1) cnt++;
         last_if = e_if;
         last_ls = e_ls;
         next_cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
